// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state and error encodings for the program loader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        FLUSH
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_LEN     = 2'b01,
        ERR_TIMEOUT = 2'b10,
        ERR_CSUM    = 2'b11
    } err_code_t;

    // Length byte value that selects a full-depth load.
    localparam int unsigned LEN_FULL = 0;

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream handshake into the loader and RAM write port out of it.
interface prog_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, ram_we, ram_addr, ram_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, ram_we, ram_addr, ram_data
    );
endinterface

// File: rtl/prog_loader_timeout.sv
// loader_timeout: counts consecutive idle cycles; expired fires on the cycle
// that would bring the count to TIMEOUT_CYCLES.
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TC = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr)     cnt_d = '0;
        else if (en) cnt_d = cnt_q + CNT_W'(1);
    end

    assign expired = en && !clr && (cnt_q == TC);
endmodule

// File: rtl/prog_loader.sv
// prog_loader: byte-stream loader filling the program RAM from address 0.
// Optional trailing checksum byte is enabled by defining PROG_LOADER_CHECKSUM_EN.
//   state | meaning
//   IDLE  | waiting for start
//   LEN   | expecting the length byte
//   DATA  | accepting data bytes, one RAM write each
//   CSUM  | expecting the checksum byte (checksum build only)
//   FLUSH | final RAM write pulse in flight
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    prog_loader_if.slave bus,
    output logic         busy,
    output logic         done,
    output logic         err,
    output err_code_t    err_code
);
    localparam int          CNT_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, ram_addr_q, ram_addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic              ram_we_q, ram_we_d, done_q, done_d, err_q, err_d;
    err_code_t         err_code_q, err_code_d;

    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  len_count;
    logic              active, xfer, expired, len_bad, last_byte;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d, csum_total;
    assign csum_total = sum_q + data;
    localparam state_t AFTER_DATA = CSUM;
`else
    localparam state_t AFTER_DATA = FLUSH;
`endif

    assign data      = bus.in_data;
    assign active    = state_q inside {LEN, DATA, CSUM};
    assign xfer      = active && bus.in_valid;
    assign len_bad   = 32'(data) > DEPTH;
    assign len_count = (32'(data) == LEN_FULL) ? CNT_W'(DEPTH) : CNT_W'(data);
    assign last_byte = (rem_q == CNT_W'(1));

    loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!active || xfer),
        .en      (active && !xfer),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = LEN;
            LEN:   if (xfer) state_d = len_bad ? IDLE : DATA;
            DATA:  if (xfer && last_byte) state_d = AFTER_DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
            CSUM:  if (xfer) state_d = (csum_total == '0) ? FLUSH : IDLE;
`else
            CSUM:  state_d = IDLE;
`endif
            FLUSH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // expired only fires in an active state with no transfer pending
        if (expired) state_d = IDLE;
    end

    always_comb begin
        addr_d     = addr_q;
        rem_d      = rem_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        done_d     = done_q;
        err_d      = err_q;
        err_code_d = err_code_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                addr_d     = '0;
                done_d     = 1'b0;
                err_d      = 1'b0;
                err_code_d = ERR_NONE;
`ifdef PROG_LOADER_CHECKSUM_EN
                sum_d      = '0;
`endif
            end
            LEN: if (xfer) begin
                if (len_bad) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_LEN;
                end else begin
                    rem_d = len_count;
                end
            end
            DATA: if (xfer) begin
                ram_we_d   = 1'b1;
                ram_addr_d = addr_q;
                ram_data_d = data;
                addr_d     = addr_q + ADDR_W'(1);
                rem_d      = rem_q - CNT_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
                sum_d      = sum_q + data;
`endif
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CSUM: if (xfer && csum_total != '0) begin
                err_d      = 1'b1;
                err_code_d = ERR_CSUM;
            end
`endif
            FLUSH: done_d = 1'b1;
            default: ;
        endcase
        if (expired) begin
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end
    end

    assign bus.in_ready = active;
    assign bus.ram_we   = ram_we_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_data = ram_data_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign err          = err_q;
    assign err_code     = err_code_q;
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader that sits directly upstream of the 16x8 program/data RAM.
- On a start pulse it accepts a length byte, then N data bytes, and drives the RAM write port sequentially from address 0.
- busy is high for the whole load; top level uses it to hold the CPU halted and give the loader the RAM write path.
- Reports completion or a coded error.

Parameters:
- ADDR_W, 4, RAM address width; depth = 2^ADDR_W.
- DATA_W, 8, byte width of the stream and the RAM.
- TIMEOUT_CYCLES, 1000000, idle cycles allowed between accepted bytes mid-load; must be >= 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a load; sampled only in IDLE.
- in_valid  in  1  stream byte valid.
- in_data  in  DATA_W  stream byte.
- in_ready  out  1  loader can accept a byte; transfer occurs when in_valid && in_ready at a rising edge.
- ram_we  out  1  RAM write enable, one cycle per byte.
- ram_addr  out  ADDR_W  RAM write address.
- ram_data  out  DATA_W  RAM write data.
- busy  out  1  load in progress.
- done  out  1  sticky: last load completed cleanly.
- err  out  1  sticky: last load aborted.
- err_code  out  2  00 none, 01 bad length, 10 timeout, 11 checksum mismatch.

Behaviour:
- Reset (async assert): state=IDLE; in_ready, ram_we, busy, done, err = 0; ram_addr, ram_data, err_code = 0. Partial RAM contents are left as written.
- All outputs are registered; in_ready is a decode of the registered state.
- IDLE
  - in_ready=0, busy=0.
  - start=1 -> LEN; clears done/err/err_code; sets internal write address to 0.
  - start is ignored in every other state.
- LEN
  - in_ready=1, busy=1.
  - On transfer: 0x00 means 2^ADDR_W bytes; 0x01..2^ADDR_W is taken as-is -> DATA.
  - Any value > 2^ADDR_W -> IDLE with err=1, err_code=01; no RAM write occurs.
- DATA
  - in_ready=1.
  - Byte accepted at edge k: ram_we=1, ram_addr=current address, ram_data=byte during cycle k..k+1 (one cycle). RAM captures at edge k+1.
  - Address increments after each accept; remaining count decrements.
  - Back-to-back transfers give back-to-back write pulses at consecutive addresses.
  - Address never wraps: count <= depth.
  - Last byte accepted -> FLUSH (or CSUM, see optional feature).
- FLUSH
  - One cycle; in_ready=0; the final write pulse is active.
  - -> IDLE with done=1. busy falls on entry to IDLE.
- Timeout
  - In LEN/DATA/CSUM a counter increments each cycle without a transfer and clears on a transfer.
  - Reaching TIMEOUT_CYCLES -> IDLE, err=1, err_code=10.
  - No pending write can exist at that point; already written bytes remain in RAM.
- in_valid while in_ready=0: the byte is not consumed; the source holds it.
- done and err are never both 1.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - DATA -> CSUM after the last data byte. CSUM has in_ready=1 and is subject to the timeout.
  - The accepted byte must make (sum of data bytes + checksum) mod 256 == 0.
  - Match -> FLUSH-equivalent -> done=1.
  - Mismatch -> IDLE with err=1, err_code=11. RAM keeps the written data.
  - Running sum is DATA_W bits, cleared on start.
- Undefined: no CSUM state, no sum register; DATA -> FLUSH directly; err_code 11 is never produced.

Decomposition:
- Package prog_loader_pkg holds:
  - state enum: IDLE, LEN, DATA, CSUM, FLUSH;
  - err_code typedef and its constants ERR_NONE, ERR_LEN, ERR_TIMEOUT, ERR_CSUM;
  - LEN_FULL encoding (0x00).
- Sub-module: loader_timeout, a parameterised idle counter with clear/enable inputs and an expired output; width is $clog2(TIMEOUT_CYCLES+1).

Test Plan:
- start; len=03; bytes 1F,E0,FF back-to-back -> three consecutive ram_we pulses at addr 0/1/2 with data 1F/E0/FF; done=1, err=0; busy low the cycle after the FLUSH cycle.
- len=00; 16 bytes 00..0E,55 with random in_valid gaps -> 16 writes, addr 0..15, last write addr 15 data 55; no write to addr 0 after addr 15; done=1.
- len=11 -> err=1, err_code=01, zero ram_we pulses, busy high for exactly the LEN period.
- TIMEOUT_CYCLES=8; len=04; two bytes then in_valid=0 -> exactly 2 writes; 8 idle cycles later err_code=10; busy=0; a following start plus a valid load succeeds.
- rst_n low mid-DATA (asynchronous, between edges) -> ram_we, busy, in_ready drop immediately; after release, state is IDLE and start is accepted.
- PROG_LOADER_CHECKSUM_EN: len=02, bytes 01,02, checksum FD -> done=1. Same with checksum FC -> err_code=11, RAM still holds 01,02.
